// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C oscillator configuration sequencer.
// Holds the FSM state enum, the (register, data) entry type, the two
// oscillator configuration tables, and the default slave address.
package i2c_cfg_pkg;

  localparam int unsigned TABLE_DEPTH = 16;
  localparam logic [6:0]  SLV_ADDR7_DEFAULT = 7'h55;

  // 0 selects the primary oscillator table, 1 the alternate part.
  localparam int unsigned OSC_SEL = 0;

  typedef enum logic [2:0] {
    S_PWR_DLY,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_NEXT,
    S_DDS_DLY,
    S_DONE,
    S_FAIL
  } cfg_state_e;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  // Entries listed from index 15 down to index 0; unused slots are zero.
  localparam cfg_entry_t [TABLE_DEPTH-1:0] CFG_TABLE_A = {
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h8404, 16'h8401, 16'h0B00, 16'h0A20, 16'h0908, 16'h0821,
    16'h074D, 16'h0602, 16'h0514, 16'h0033, 16'h8400
  };

  localparam cfg_entry_t [TABLE_DEPTH-1:0] CFG_TABLE_B = {
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h8404, 16'h8401, 16'h0B00, 16'h0A20, 16'h0908, 16'h0821,
    16'h0762, 16'h0603, 16'h0515, 16'h0033, 16'h8400
  };

  localparam cfg_entry_t [TABLE_DEPTH-1:0] CFG_TABLE =
    (OSC_SEL == 0) ? CFG_TABLE_A : CFG_TABLE_B;

endpackage

// File: rtl/i2c_cfg_sequencer_delay_counter.sv
// Shared 32-bit phase counter.
// Ports: clk_i/rst_n_i clock and async active-low reset; en_i advances the
// count; clear_i restarts it from zero (takes priority over en_i); term_i is
// the terminal value; tc_c_o is high (combinationally) while count == term_i.
module cfg_delay_counter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic [31:0] term_i,
  output logic        tc_c_o
);

  logic [31:0] cnt_q;

  // Free-running up-count while enabled; a clear starts a new phase at zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign tc_c_o = (cnt_q == term_i);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Power-up configuration sequencer for the pixel-oscillator I2C write master.
// Waits STARTUP_DLY cycles, then writes each (reg, data) table entry through
// a level WR_REQ / pulsed WR_DONE handshake, retrying NACKs and timeouts,
// and raises DDS_START DDS_DLY cycles after the last successful write.
// Ports:
//   CLOCK_IN, RESET_N         clock, async active-low reset (release is
//                             expected to be synchronous to CLOCK_IN)
//   WR_REQ/WR_SLV/WR_REG/WR_DATA  write request and payload to the master
//   WR_DONE/WR_NACK           completion pulse and ack status from master
//   REG_IDX                   entry in progress, NUM_REGS when complete
//   CFG_DONE/CFG_FAIL/DDS_START   sticky status outputs
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 11,
  parameter int unsigned STARTUP_DLY = 91000000,
  parameter int unsigned DDS_DLY     = 151000000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 4000,
  parameter int unsigned WR_TIMEOUT  = 20000,
  parameter logic [6:0]  SLV_ADDR7   = SLV_ADDR7_DEFAULT
) (
  input  logic       CLOCK_IN,
  input  logic       RESET_N,
  output logic       WR_REQ,
  output logic [6:0] WR_SLV,
  output logic [7:0] WR_REG,
  output logic [7:0] WR_DATA,
  input  logic       WR_DONE,
  input  logic       WR_NACK,
  output logic [3:0] REG_IDX,
  output logic       CFG_DONE,
  output logic       CFG_FAIL,
  output logic       DDS_START
);

  localparam int unsigned RETRY_W =
    ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);

  localparam logic [31:0] STARTUP_TERM = 32'(STARTUP_DLY - 1);
  localparam logic [31:0] DDS_TERM     = 32'(DDS_DLY - 1);
  localparam logic [31:0] GAP_TERM     = 32'(RETRY_GAP - 1);
  localparam logic [31:0] TIMEOUT_TERM = 32'(WR_TIMEOUT - 1);

  cfg_state_e         state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [3:0]         idx_q, idx_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               dds_q, dds_d;
  cfg_entry_t         entry_q;

  logic        cnt_en;
  logic        cnt_clear;
  logic [31:0] cnt_term;
  logic        cnt_tc;

  // One counter serves every timed phase; the active state picks its terminal.
  cfg_delay_counter u_dly (
    .clk_i   (CLOCK_IN),
    .rst_n_i (RESET_N),
    .en_i    (cnt_en),
    .clear_i (cnt_clear),
    .term_i  (cnt_term),
    .tc_c_o  (cnt_tc)
  );

  // State and output registers.
  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_PWR_DLY;
      retry_q <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      dds_q   <= 1'b0;
      entry_q <= CFG_TABLE[0];
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      dds_q   <= dds_d;
      // Looked up from the next index so the payload settles before WR_REQ.
      entry_q <= CFG_TABLE[idx_d];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    req_d     = req_q;
    done_d    = done_q;
    fail_d    = fail_q;
    dds_d     = dds_q;
    cnt_en    = 1'b1;
    cnt_clear = 1'b0;
    cnt_term  = '0;

    unique case (state_q)
      S_PWR_DLY: begin
        cnt_term = STARTUP_TERM;
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        req_d     = 1'b1;
        cnt_clear = 1'b1;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        cnt_term = TIMEOUT_TERM;
        // A completion pulse wins over a timeout landing in the same cycle.
        if (WR_DONE && !WR_NACK) begin
          req_d   = 1'b0;
          retry_d = '0;
          state_d = S_NEXT;
        end else if (WR_DONE || cnt_tc) begin
          req_d     = 1'b0;
          cnt_clear = 1'b1;
          if (32'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_GAP;
          end else begin
            fail_d  = 1'b1;
            state_d = S_FAIL;
          end
        end
      end

      S_GAP: begin
        cnt_term = GAP_TERM;
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          state_d   = S_ISSUE;
        end
      end

      S_NEXT: begin
        idx_d     = idx_q + 4'd1;
        cnt_clear = 1'b1;
        // Compare one bit wider so NUM_REGS = 16 still terminates.
        if (5'(idx_q) + 5'd1 == 5'(NUM_REGS)) begin
          done_d  = 1'b1;
          state_d = S_DDS_DLY;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_DDS_DLY: begin
        cnt_term = DDS_TERM;
        if (cnt_tc) begin
          dds_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        cnt_en = 1'b0;
        req_d  = 1'b0;
      end

      S_FAIL: begin
        cnt_en = 1'b0;
        req_d  = 1'b0;
      end

      default: begin
        req_d   = 1'b0;
        state_d = S_FAIL;
      end
    endcase
  end

  assign WR_REQ    = req_q;
  assign WR_SLV    = SLV_ADDR7;
  assign WR_REG    = entry_q.reg_addr;
  assign WR_DATA   = entry_q.data;
  assign REG_IDX   = idx_q;
  assign CFG_DONE  = done_q;
  assign CFG_FAIL  = fail_q;
  assign DDS_START = dds_q;

endmodule
